fv_enc_noise_add: RTL and testbench

FV_ENC_NOISE_ADD -- requirements
Module: fv_enc_noise_add

---
 rtl/fv_enc_pkg.sv | 18 +
 rtl/fv_mod_reduce3.sv | 28 ++
 rtl/fv_enc_noise_add.sv | 155 +++++++++++++++
 tb/tb_fv_enc_noise_add.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_enc_pkg.sv
// Shared parameters and helpers for the FV encryption noise-addition datapath.
// The coefficient type is common with multiplier_top so both ends agree on width.
package fv_enc_pkg;

  localparam int N_DEF  = 4;
  localparam int QW_DEF = 5;
  localparam int Q_DEF  = 29;
  localparam int TW_DEF = 1;
  localparam int EW_DEF = 3;

  typedef logic [QW_DEF-1:0] coef_t;

  // Plaintext scaling factor: floor(q / t) with t = 2^tw.
  function automatic int fv_delta(input int q, input int tw);
    return q / (1 << tw);
  endfunction

endpackage

// File: rtl/fv_mod_reduce3.sv
// Combinational reduction of s < 3Q into [0, Q) using two conditional subtracts.
module fv_mod_reduce3
  import fv_enc_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int Q  = Q_DEF
) (
  input  logic [QW+1:0] s_i,
  output logic [QW-1:0] r_o
);

  localparam logic [QW+1:0] Q_X  = (QW+2)'(Q);
  localparam logic [QW+1:0] Q2_X = (QW+2)'(2 * Q);

  logic [QW+1:0] t1;

  always_comb begin
    t1 = s_i;
    if (s_i >= Q2_X) begin
      t1 = s_i - Q_X;
    end
    r_o = QW'(t1);
    if (t1 >= Q_X) begin
      r_o = QW'(t1 - Q_X);
    end
  end

endmodule

// File: rtl/fv_enc_noise_add.sv
// Computes c0 = (z + e + DELTA*m) mod Q over a three-way joined stream,
// through a two-stage elastic pipeline with coefficient indexing and framing check.
module fv_enc_noise_add
  import fv_enc_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int QW = QW_DEF,
  parameter int Q  = Q_DEF,
  parameter int TW = TW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic          clk,
  input  logic          s_rst,
  input  logic          z_vld_i,
  output logic          z_rdy_o,
  input  logic [QW-1:0] z_data_i,
  input  logic          z_last_i,
  input  logic          e_vld_i,
  output logic          e_rdy_o,
  input  logic [EW-1:0] e_data_i,
  input  logic          e_last_i,
  input  logic          m_vld_i,
  output logic          m_rdy_o,
  input  logic [TW-1:0] m_data_i,
  input  logic          m_last_i,
  output logic          c_vld_o,
  input  logic          c_rdy_i,
  output logic [QW-1:0] c_data_o,
  output logic          c_last_o,
  output logic          err_o
);

  localparam int AW    = QW + 2;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int DELTA = fv_delta(Q, TW);

  localparam logic [AW-1:0] Q_X      = AW'(Q);
  localparam logic [AW-1:0] DELTA_X  = AW'(DELTA);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          s1_vld_q, s1_vld_d;
  logic [AW-1:0] s1_sum_q, s1_sum_d;
  logic [AW-1:0] s1_ep_q,  s1_ep_d;
  logic          s1_last_q, s1_last_d;
  logic          c_vld_q,  c_vld_d;
  logic [QW-1:0] c_data_q, c_data_d;
  logic          c_last_q, c_last_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic          err_q,    err_d;

  logic          c_pop;
  logic          s2_load;
  logic          s1_free;
  logic          xfer;
  logic          idx_is_last;
  logic [AW-1:0] z_x;
  logic [AW-1:0] dm_x;
  logic [AW-1:0] e_x;
  logic [AW-1:0] e_map;
  logic [AW-1:0] s_sum;
  logic [QW-1:0] red;

  // Each stage loads when empty or when its content leaves in the same cycle.
  assign c_pop   = c_vld_q & c_rdy_i;
  assign s2_load = s1_vld_q & (~c_vld_q | c_rdy_i);
  assign s1_free = ~s1_vld_q | s2_load;
  assign xfer    = z_vld_i & e_vld_i & m_vld_i & s1_free & ~s_rst;

  assign z_rdy_o = xfer;
  assign e_rdy_o = xfer;
  assign m_rdy_o = xfer;

  assign idx_is_last = (idx_q == LAST_IDX);

  // Negative errors are lifted into [0, Q) so stage 2 only ever adds.
  assign z_x   = AW'(z_data_i);
  assign dm_x  = DELTA_X * AW'(m_data_i);
  assign e_x   = {{(AW-EW){e_data_i[EW-1]}}, e_data_i};
  assign e_map = e_data_i[EW-1] ? (e_x + Q_X) : e_x;
  assign s_sum = s1_sum_q + s1_ep_q;

  fv_mod_reduce3 #(
    .QW(QW),
    .Q (Q)
  ) u_reduce (
    .s_i(s_sum),
    .r_o(red)
  );

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_sum_d  = s1_sum_q;
    s1_ep_d   = s1_ep_q;
    s1_last_d = s1_last_q;
    c_vld_d   = c_vld_q;
    c_data_d  = c_data_q;
    c_last_d  = c_last_q;
    idx_d     = idx_q;
    err_d     = err_q;

    if (s1_free) begin
      s1_vld_d = xfer;
    end

    if (xfer) begin
      s1_sum_d  = z_x + dm_x;
      s1_ep_d   = e_map;
      s1_last_d = idx_is_last;
      idx_d     = idx_is_last ? '0 : idx_q + 1'b1;
      // Framing check only flags; it never alters data or index sequencing.
      if ((z_last_i != idx_is_last) || (e_last_i != idx_is_last) ||
          (m_last_i != idx_is_last)) begin
        err_d = 1'b1;
      end
    end

    if (s2_load) begin
      c_vld_d  = 1'b1;
      c_data_d = red;
      c_last_d = s1_last_q;
    end else if (c_pop) begin
      c_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      s1_vld_q  <= 1'b0;
      s1_sum_q  <= '0;
      s1_ep_q   <= '0;
      s1_last_q <= 1'b0;
      c_vld_q   <= 1'b0;
      c_data_q  <= '0;
      c_last_q  <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_sum_q  <= s1_sum_d;
      s1_ep_q   <= s1_ep_d;
      s1_last_q <= s1_last_d;
      c_vld_q   <= c_vld_d;
      c_data_q  <= c_data_d;
      c_last_q  <= c_last_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  assign c_vld_o  = c_vld_q;
  assign c_data_o = c_data_q;
  assign c_last_o = c_last_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_fv_enc_noise_add.sv
// Bench for fv_enc_noise_add: directed and random coefficients checked against
// an arithmetic reference of (z + e + DELTA*m) mod Q with a queue scoreboard.
module tb_fv_enc_noise_add;

  localparam int N     = 4;
  localparam int QW    = 5;
  localparam int Q     = 29;
  localparam int TW    = 1;
  localparam int EW    = 3;
  localparam int DELTA = Q / (1 << TW);

  logic          clk = 1'b0;
  logic          s_rst = 1'b1;
  logic          z_vld = 1'b0, z_rdy, z_last = 1'b0;
  logic [QW-1:0] z_data = '0;
  logic          e_vld = 1'b0, e_rdy, e_last = 1'b0;
  logic [EW-1:0] e_data = '0;
  logic          m_vld = 1'b0, m_rdy, m_last = 1'b0;
  logic [TW-1:0] m_data = '0;
  logic          c_vld, c_rdy = 1'b1, c_last, err;
  logic [QW-1:0] c_data;

  always #5 clk = ~clk;

  fv_enc_noise_add #(.N(N), .QW(QW), .Q(Q), .TW(TW), .EW(EW)) dut (
    .clk     (clk),
    .s_rst   (s_rst),
    .z_vld_i (z_vld),
    .z_rdy_o (z_rdy),
    .z_data_i(z_data),
    .z_last_i(z_last),
    .e_vld_i (e_vld),
    .e_rdy_o (e_rdy),
    .e_data_i(e_data),
    .e_last_i(e_last),
    .m_vld_i (m_vld),
    .m_rdy_o (m_rdy),
    .m_data_i(m_data),
    .m_last_i(m_last),
    .c_vld_o (c_vld),
    .c_rdy_i (c_rdy),
    .c_data_o(c_data),
    .c_last_o(c_last),
    .err_o   (err)
  );

  typedef struct {
    int data;
    bit last;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, model_idx = 0, xfer_cnt = 0;
  int stall_base = 0, stall_left = 0, stall_xfers = 0;
  int rst_n_cyc = 0, ovr_val = -1, hold_d = 0;
  bit exp_err = 0, hold_v = 0, hold_l = 0, lat_chk = 0, rnd_rdy = 0, xfer = 0;

  function automatic int ref_c(input int z, input int e, input int m);
    int v;
    v = (z + e + DELTA * m) % Q;
    if (v < 0) v += Q;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, score, then return just after the rising edge.
  task automatic cycle();
    exp_t ex;
    if (rnd_rdy) c_rdy = ($urandom_range(0, 3) != 0);
    else         c_rdy = (stall_left == 0);
    @(negedge clk);
    xfer = 0;
    if (s_rst) begin
      chk("rst_rdy", {z_rdy, e_rdy, m_rdy}, 0);
      if (rst_n_cyc > 0) begin
        chk("rst_c_vld", c_vld, 0);
        chk("rst_c_last", c_last, 0);
        chk("rst_c_data", c_data, 0);
        chk("rst_err", err, 0);
      end
      rst_n_cyc++;
      exp_q.delete();
      model_idx = 0;
      exp_err = 0;
      hold_v = 0;
    end else begin
      rst_n_cyc = 0;
      chk("err", err, exp_err);
      if (hold_v) begin
        chk("hold_vld", c_vld, 1);
        chk("hold_data", c_data, hold_d);
        chk("hold_last", c_last, hold_l);
      end
      if (c_vld && c_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", c_vld, 0);
        end else begin
          ex = exp_q.pop_front();
          $display("out t=%0d data=%0d last=%0d exp_data=%0d exp_last=%0d",
                   cyc, c_data, c_last, ex.data, ex.last);
          chk("c_data", c_data, ex.data);
          chk("c_last", c_last, ex.last);
          if (lat_chk) chk("latency", cyc - ex.t, 2);
        end
      end
      hold_v = c_vld && !c_rdy;
      hold_d = c_data;
      hold_l = c_last;
      chk("rdy_together", (z_rdy == e_rdy) && (e_rdy == m_rdy), 1);
      chk("rdy_join", z_rdy & ~(z_vld & e_vld & m_vld), 0);
      if (stall_left > 0 && (xfer_cnt - stall_base) >= 2) chk("stall_rdy", z_rdy, 0);
      if (z_rdy) begin
        ex.data = (ovr_val >= 0) ? ovr_val
                                 : ref_c(int'(z_data), int'($signed(e_data)), int'(m_data));
        ex.last = (model_idx == N - 1);
        ex.t    = cyc;
        exp_q.push_back(ex);
        if (z_last != ex.last || e_last != ex.last || m_last != ex.last) exp_err = 1;
        model_idx = (model_idx + 1) % N;
        xfer = 1;
        xfer_cnt++;
      end
      if (stall_left == 1) stall_xfers = xfer_cnt - stall_base;
      if (stall_left > 0) stall_left--;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int z, input int e, input int m, input int ovr, input bit bad_zlast);
    int n;
    bit lst;
    n = 0;
    lst = (model_idx == N - 1);
    z_data = z[QW-1:0];
    e_data = e[EW-1:0];
    m_data = m[TW-1:0];
    z_last = lst ^ bad_zlast;
    e_last = lst;
    m_last = lst;
    ovr_val = ovr;
    z_vld = 1; e_vld = 1; m_vld = 1;
    do begin
      cycle();
      n++;
    end while (!xfer && n < 200);
    chk("send_xfer", xfer, 1);
    z_vld = 0; e_vld = 0; m_vld = 0;
    ovr_val = -1;
  endtask

  task automatic gap(input int k);
    int r;
    for (int i = 0; i < k; i++) begin
      r = $urandom_range(0, 6);
      {z_vld, e_vld, m_vld} = r[2:0];
      z_data = QW'($urandom_range(0, Q - 1));
      cycle();
    end
    z_vld = 0; e_vld = 0; m_vld = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    z_vld = 0; e_vld = 0; m_vld = 0;
    while (exp_q.size() > 0 && n < 300) begin
      cycle();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int z29 [4] = '{1, 2, 3, 4};
    int z30 [4] = '{24, 25, 26, 27};
    int e30 [4] = '{1, -1, 2, -2};
    int m30 [4] = '{1, 1, 0, 1};
    int c30 [4] = '{10, 9, 28, 10};

    for (int i = 0; i < 3; i++) cycle();
    s_rst = 0;
    cycle();

    // Plain pass-through with latency check.
    lat_chk = 1;
    for (int i = 0; i < 4; i++) send(z29[i], 0, 0, z29[i], 0);
    drain();

    for (int i = 0; i < 4; i++) send(z30[i], e30[i], m30[i], c30[i], 0);
    drain();

    // Reduction boundaries, then one filler to close the polynomial.
    send(28, -1, 1, 12, 0);
    send(0, -4, 0, 25, 0);
    send(28, 0, 0, 28, 0);
    send(3, 3, 1, -1, 0);
    drain();

    // Output stall mid-polynomial.
    lat_chk = 0;
    send(7, 1, 0, -1, 0);
    drain();
    stall_base = xfer_cnt;
    stall_left = 5;
    for (int i = 0; i < 4; i++) send(10 + i, i - 2, i % 2, -1, 0);
    drain();
    chk("stall_absorb", stall_xfers, 2);

    // Random data, gaps and output backpressure.
    rnd_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      send($urandom_range(0, Q - 1), int'($urandom_range(0, 7)) - 4,
           $urandom_range(0, 1), -1, 0);
    end
    while (model_idx != 0) send($urandom_range(0, Q - 1), 0, 1, -1, 0);
    rnd_rdy = 0;
    drain();

    // Framing error on the third coefficient, sticky until reset.
    for (int i = 0; i < 4; i++) send(i + 20, 1, 1, -1, (i == 2));
    drain();
    gap(3);

    // Reset mid-polynomial discards in-flight data.
    lat_chk = 1;
    send(11, 0, 0, 11, 0);
    send(12, 0, 0, 12, 0);
    z_vld = 1; e_vld = 1; m_vld = 1;
    s_rst = 1;
    cycle();
    cycle();
    s_rst = 0;
    z_vld = 0; e_vld = 0; m_vld = 0;
    for (int i = 0; i < 4; i++) send(5 + i, 0, 0, 5 + i, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
